// File: rtl/mac_accum_int32.sv
// mac_accum_int32: accumulates a programmed number of product words from the
// upstream integer multiplier and presents the sum on a valid/ready port.
// Optional build macro: MAC_ACCUM_OVF_FLAG_EN adds the sticky out_ovf flag
// for signed two's-complement overflow within a job.
module mac_accum_int32 #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] in_prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MAC_ACCUM_OVF_FLAG_EN
    output logic             out_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_r;
    logic [WIDTH-1:0] sum;
    logic             accept;
    logic             last;

    // Handshake flags are pure state decodes, so no input reaches them
    // combinationally; in_ready in particular ignores in_valid.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept = in_valid && in_ready;
    assign sum    = acc + in_prod;              // wraps modulo 2^WIDTH
    assign last   = (cnt == len_r - LEN_W'(1)); // only meaningful in ACCUM (len_r >= 1)

`ifdef MAC_ACCUM_OVF_FLAG_EN
    logic ovf;
    logic add_ovf;
    // Signed overflow: operands share a sign but the result's sign differs.
    assign add_ovf = (acc[WIDTH-1] == in_prod[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
    assign out_ovf = ovf;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (accept && last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: job setup, accumulation and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            len_r   <= '0;
            out_sum <= '0;
`ifdef MAC_ACCUM_OVF_FLAG_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_r <= len;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef MAC_ACCUM_OVF_FLAG_EN
                        ovf   <= 1'b0;
`endif
                        if (len == '0) out_sum <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= sum;
                        cnt <= cnt + LEN_W'(1);
`ifdef MAC_ACCUM_OVF_FLAG_EN
                        ovf <= ovf | add_ovf;
`endif
                        // Final sum lands on out_sum in the same edge as DONE.
                        if (last) out_sum <= sum;
                    end
                end
                default: ;  // DONE holds everything until the handshake
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum_int32.sv
// Directed testbench for mac_accum_int32. Inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_mac_accum_int32;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] in_prod;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef MAC_ACCUM_OVF_FLAG_EN
    logic             out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_accum_int32 #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_prod  (in_prod),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_sum  (out_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MAC_ACCUM_OVF_FLAG_EN
        .out_ovf  (out_ovf),
`endif
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; in_prod = '0; in_valid = 1'b0; out_ready = 1'b0;
        step(); step();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {out_valid, in_ready, busy});
        end
        checks++;
        if (out_sum !== 32'd0) begin
            errors++; $display("FAIL reset_sum: got %h want 00000000", out_sum);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int prods[3] = '{5, 7, 11};
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL basic_accum_%0d: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
            in_valid = 1'b1; in_prod = prods[i];
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd23 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_result: valid=%b sum=%0d busy=%b rdy=%b want 1 23 1 0", out_valid, out_sum, busy, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_after_hs: valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_len0();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL len0_result: valid=%b sum=%h rdy=%b want 1 0 0", out_valid, out_sum, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL len0_idle: valid=%b rdy=%b busy=%b want 0 0 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_wrap_gaps();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'hFFFF_FFFF;
        step();
        in_valid = 1'b0; in_prod = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL gap_%0d: in_ready=%b out_valid=%b want 1 0", i, in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b1; in_prod = 32'h0000_0002;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h0000_0001) begin
            errors++; $display("FAIL wrap_result: valid=%b sum=%h want 1 00000001", out_valid, out_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'd42;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 32'd42 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold_%0d: valid=%b sum=%0d rdy=%b want 1 42 0", i, out_valid, out_sum, in_ready);
            end
            start = (i == 2); len = 8'd5;
            step();
        end
        // start asserted in the handshake cycle must also be ignored
        start = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_release: valid=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL hold_no_restart: busy=%b want 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'd100;
        step();
        in_prod = 32'd200;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b000 || out_sum !== 32'd0) begin
            errors++; $display("FAIL rst_mid: flags=%b sum=%0d want 000 0", {out_valid, in_ready, busy}, out_sum);
        end
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'd9;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd9) begin
            errors++; $display("FAIL rst_next_job: valid=%b sum=%0d want 1 9", out_valid, out_sum);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

`ifdef MAC_ACCUM_OVF_FLAG_EN
    task automatic test_ovf();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'h7FFF_FFFF;
        step();
        in_prod = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'h8000_0000 || out_ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set: valid=%b sum=%h ovf=%b want 1 80000000 1", out_valid, out_sum, out_ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_prod = 32'd3;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 32'd3 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: valid=%b sum=%0d ovf=%b want 1 3 0", out_valid, out_sum, out_ovf);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap_gaps();
        test_hold();
        test_rst_mid();
`ifdef MAC_ACCUM_OVF_FLAG_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
